// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobe, per-key debounce, press/release event FIFO.
// Ports: CLOCK_50, reset (sync, high); cols (active-low sense), rows (inout, active row 0, others Z);
// pad (debounced state); evt_valid/evt_ready/evt_key/evt_press show-ahead stream; evt_overflow sticky.
// Option macro KEYPAD_RELEASE_EVT_EN: also report 1->0 toggles as events.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 500000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int NK = ROWS * COLS,
  localparam int KW = (NK > 1) ? $clog2(NK) : 1
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [COLS-1:0] cols,
  inout  wire  [ROWS-1:0] rows,
  output logic [NK-1:0]   pad,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [KW-1:0]   evt_key,
  output logic            evt_press,
  output logic            evt_overflow
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] CNT_FULL = AW1'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_LAST = AW1'(FIFO_DEPTH - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE - 1);
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic [COLS-1:0] cs1, cs2;
  logic [DW-1:0]   div;
  logic            tick;
  logic [RW-1:0]   row_ptr;

  logic [3:0]      dcnt   [NK];
  logic [3:0]      dcnt_n [NK];
  logic [NK-1:0]   pad_n, tgl;
  logic [NK-1:0]   pend, pend_n, set, clr;
  logic            ovf_n;

  logic            gnt_v;
  logic [KW-1:0]   gnt_k;
  logic            full_blk;

  logic            push_v, push_p;
  logic [KW-1:0]   push_k;

  logic [KW:0]     fmem [FIFO_DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     fcnt;
  logic            pop;
  logic            head_p;

  assign tick = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cs1     <= '1;
      cs2     <= '1;
      div     <= '0;
      row_ptr <= '0;
    end else begin
      cs1 <= cols;
      cs2 <= cs1;
      div <= tick ? '0 : div + 1'b1;
      if (tick)
        row_ptr <= (row_ptr == RW'(ROWS - 1)) ? '0 : row_ptr + 1'b1;
    end
  end

  // Rows float during reset; the strobe appears as soon as reset drops.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign rows[r] = (!reset && row_ptr == RW'(r)) ? 1'b0 : 1'bz;
  end

  always_comb begin
    pad_n = pad;
    tgl   = '0;
    for (int k = 0; k < NK; k++)
      dcnt_n[k] = dcnt[k];
    if (tick) begin
      for (int r = 0; r < ROWS; r++) begin
        if (int'(row_ptr) == r) begin
          for (int c = 0; c < COLS; c++) begin
            if (!cs2[c] == pad[r*COLS+c]) begin
              dcnt_n[r*COLS+c] = '0;
            end else if (dcnt[r*COLS+c] == DB_LAST) begin
              dcnt_n[r*COLS+c] = '0;
              pad_n[r*COLS+c]  = ~pad[r*COLS+c];
              tgl[r*COLS+c]    = 1'b1;
            end else begin
              dcnt_n[r*COLS+c] = dcnt[r*COLS+c] + 4'd1;
            end
          end
        end
      end
    end
  end

  // A push already in flight still needs a slot, so it counts
  // toward the full check.
  always_comb begin
    gnt_k = '0;
    for (int k = NK - 1; k >= 0; k--)
      if (pend[k]) gnt_k = KW'(k);
    full_blk = (fcnt == CNT_FULL) ||
               (push_v && fcnt == CNT_LAST);
    gnt_v = (|pend) && !full_blk;
    clr = '0;
    if (gnt_v) clr[gnt_k] = 1'b1;
    set    = tgl & (REL ? {NK{1'b1}} : pad_n);
    pend_n = (pend & ~clr) | set;
    ovf_n  = evt_overflow | (|(set & pend & ~clr));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pad          <= '0;
      pend         <= '0;
      evt_overflow <= 1'b0;
      push_v       <= 1'b0;
      push_k       <= '0;
      push_p       <= 1'b0;
      for (int k = 0; k < NK; k++)
        dcnt[k] <= '0;
    end else begin
      pad          <= pad_n;
      pend         <= pend_n;
      evt_overflow <= ovf_n;
      push_v       <= gnt_v;
      push_k       <= gnt_k;
      push_p       <= REL ? pad[gnt_k] : 1'b1;
      for (int k = 0; k < NK; k++)
        dcnt[k] <= dcnt_n[k];
    end
  end

  assign evt_valid = (fcnt != '0);
  assign pop       = evt_valid && evt_ready;
  assign {evt_key, head_p} = fmem[rp];
  assign evt_press = head_p | ~REL;

  always_ff @(posedge CLOCK_50) begin
    if (push_v)
      fmem[wp] <= {push_k, push_p};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push_v) wp <= wp + 1'b1;
      if (pop)    rp <= rp + 1'b1;
      fcnt <= fcnt + AW1'(push_v) - AW1'(pop);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x4 matrix, SCAN_DIV=8, DEBOUNCE=3.
// Keypad model ties pressed keys' columns low while their row is strobed.
`timescale 1ns/1ps
module tb_keypad_scanner;

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  localparam int FR = 32;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols;
  wire  [3:0]  rows;
  logic [15:0] pad;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic        evt_overflow;

  logic [15:0] keys = '0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base;
  logic [4:0] evq [$];
  int evc [$];
  int pad_cyc = 0;
  int vr_cyc = 0;
  logic pv = 0, pr = 0, pp = 0;
  logic [3:0] pk = '0;
  logic [15:0] ppad = '0;

  typedef struct packed {
    logic [15:0]     keys;
    logic [3:0]      nfr;
    logic [15:0]     exp_pad;
    logic [1:0]      nev;
    logic [2:0][4:0] ev;
    logic            chk_lat;
    logic            consec;
  } step_t;
  step_t tbl [10];

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8),
    .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .cols(cols),
    .rows(rows),
    .pad(pad),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_press(evt_press),
    .evt_overflow(evt_overflow)
  );

  pullup (rows[0]);
  pullup (rows[1]);
  pullup (rows[2]);
  pullup (rows[3]);

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && rows[r] == 1'b0)
          cols[c] = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] ev(input int k, input logic p);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, p};
  endfunction

  function automatic step_t mk(
    input logic [15:0] k, input int nf, input logic [15:0] p,
    input int ne, input logic [4:0] e0, input logic [4:0] e1,
    input logic [4:0] e2, input logic lat, input logic con);
    step_t s;
    s.keys = k;
    s.nfr = 4'(nf);
    s.exp_pad = p;
    s.nev = 2'(ne);
    s.ev[0] = e0;
    s.ev[1] = e1;
    s.ev[2] = e2;
    s.chk_lat = lat;
    s.consec = con;
    return s;
  endfunction

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (pv && !pr && evt_valid) begin
        chk("hold_key", evt_key, pk);
        chk("hold_press", evt_press, pp);
      end
      if (evt_valid && !pv) vr_cyc = cyc;
      if (pad != ppad) pad_cyc = cyc;
      if (evt_valid && evt_ready) begin
        evq.push_back({evt_key, evt_press});
        evc.push_back(cyc);
      end
    end
    pv = evt_valid && !reset;
    pr = evt_ready;
    pk = evt_key;
    pp = evt_press;
    ppad = pad;
  end

  task automatic frames(input int n);
    repeat (n * FR) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge CLOCK_50);
    #1 reset = 1'b1;
    repeat (n) @(posedge CLOCK_50);
    #1;
    chk("rst_rows_undriven", rows, 4'hF);
    chk("rst_pad", pad, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf", evt_overflow, 0);
    reset = 1'b0;
    #1;
    chk("rel_row0_low", rows, 4'hE);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(16'h0200, 3, 16'h0200, 1, ev(9,1), 0, 0, 1, 0);
    tbl[1] = mk(16'h0000, 3, 16'h0000, REL ? 1 : 0, ev(9,0), 0, 0, 0, 0);
    tbl[2] = mk(16'h0040, 2, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(16'h0000, 3, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(16'h00B0, 3, 16'h00B0, 3, ev(4,1), ev(5,1), ev(7,1), 0, 1);
    tbl[5] = mk(16'h0000, 3, 16'h0000, REL ? 3 : 0, ev(4,0), ev(5,0), ev(7,0), 0, 0);
    tbl[6] = mk(16'h0001, 2, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[7] = mk(16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[8] = mk(16'h0001, 2, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[9] = mk(16'h0000, 1, 16'h0000, 0, 0, 0, 0, 0, 0);

    do_reset(5);
    chk("post_rst_pad", pad, 0);
    chk("post_rst_valid", evt_valid, 0);
    repeat (7) @(posedge CLOCK_50);
    #1 chk("row0_slot_end", rows, 4'hE);
    @(posedge CLOCK_50);
    #1 chk("row1_start", rows, 4'hD);
    repeat (FR - 8) @(posedge CLOCK_50);
    #1;

    for (int i = 0; i < 10; i++) begin
      base = evq.size();
      chk($sformatf("s%0d_frame_align", i), rows, 4'hE);
      keys = tbl[i].keys;
      frames(int'(tbl[i].nfr));
      chk($sformatf("s%0d_pad", i), pad, tbl[i].exp_pad);
      chk($sformatf("s%0d_nev", i), evq.size() - base, tbl[i].nev);
      for (int j = 0; j < int'(tbl[i].nev); j++)
        if (base + j < evq.size())
          chk($sformatf("s%0d_ev%0d", i, j), evq[base+j], tbl[i].ev[j]);
      chk($sformatf("s%0d_ovf", i), evt_overflow, 0);
      if (tbl[i].chk_lat)
        chk($sformatf("s%0d_latency", i), vr_cyc - pad_cyc, 2);
      if (tbl[i].consec && evq.size() >= base + 3)
        chk($sformatf("s%0d_consec", i), evc[base+2] - evc[base], 2);
    end

    evt_ready = 1'b0;
    base = evq.size();
    keys = 16'h001F;
    frames(3);
    chk("A_pad", pad, 16'h001F);
    chk("A_valid", evt_valid, 1);
    chk("A_head_key", evt_key, 0);
    chk("A_head_press", evt_press, 1);
    chk("A_no_pop", evq.size() - base, 0);
    chk("A_ovf_clear", evt_overflow, 0);
    keys = 16'h000F;
    frames(3);
    chk("A_pad_rel4", pad, 16'h000F);
    chk("A_ovf", evt_overflow, REL);
    chk("A_still_held", evq.size() - base, 0);
    evt_ready = 1'b1;
    frames(1);
    chk("A_drain_n", evq.size() - base, 5);
    if (evq.size() >= base + 5) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("A_ev%0d", j), evq[base+j], ev(j, 1'b1));
      chk("A_key4_last", evq[base+4], ev(4, !REL));
    end
    base = evq.size();
    keys = 16'h0000;
    frames(3);
    chk("A_rel_pad", pad, 0);
    chk("A_rel_nev", evq.size() - base, REL ? 4 : 0);
    chk("A_ovf_sticky", evt_overflow, REL);

    base = evq.size();
    keys = 16'h0008;
    frames(2);
    chk("B_pad_pre", pad, 0);
    do_reset(3);
    frames(2);
    chk("B_pad_2fr", pad, 0);
    chk("B_no_evt", evq.size() - base, 0);
    frames(1);
    chk("B_pad_3fr", pad, 16'h0008);
    chk("B_nev", evq.size() - base, 1);
    if (evq.size() > base)
      chk("B_ev", evq[base], ev(3, 1'b1));
    keys = 16'h0000;
    frames(3);
    chk("B_rel_pad", pad, 0);

    evt_ready = 1'b0;
    keys = 16'h000F;
    frames(3);
    chk("C_valid_full", evt_valid, 1);
    keys = 16'h0000;
    do_reset(2);
    chk("C_valid_after", evt_valid, 0);
    evt_ready = 1'b1;
    base = evq.size();
    frames(3);
    chk("C_no_stale", evq.size() - base, 0);
    chk("C_pad", pad, 0);
    chk("C_ovf", evt_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
